// File: rtl/generic_cbus_master_xfer_ctl_pkg.sv
// Shared types and constants for the CBUS master transfer controller.
package cbus_xfer_pkg;

  typedef enum logic [1:0] {
    XFER_IDLE = 2'd0,
    XFER_XFER = 2'd1,
    XFER_DONE = 2'd2
  } xfer_state_e;

  localparam logic CBUS_DIR_WR = 1'b0;
  localparam logic CBUS_DIR_RD = 1'b1;

  // Width of the in-beat byte offset for a given bus width.
  function automatic int unsigned cbus_off_w(input int unsigned bus_bytes);
    return $clog2(bus_bytes);
  endfunction

  localparam int unsigned CBUS_OFF_W_MAX = cbus_off_w(16);

endpackage

// File: rtl/generic_cbus_master_xfer_ctl_if.sv
// Local-controller command port and CBUS beat port of the transfer controller.
interface generic_cbus_master_xfer_ctl_if #(
  parameter int unsigned BUS_BYTES = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BCNT_W    = 10
);
  logic                 ctl_req;
  logic                 ctl_dir;
  logic [ADDR_W-1:0]    ctl_address;
  logic [BCNT_W-1:0]    ctl_bytecnt;
  logic                 big_endian_q;
  logic                 ctl_ready;
  logic                 ctl_done;
  logic                 cbus_req;
  logic                 cbus_dir;
  logic [ADDR_W-1:0]    cbus_address;
  logic [BCNT_W-1:0]    cbus_bytecnt;
  logic [BUS_BYTES-1:0] cbus_byten;
  logic                 cbus_first;
  logic                 cbus_last;
  logic                 cbus_wready;
  logic                 cbus_rready;

  modport master (
    input  ctl_req, ctl_dir, ctl_address, ctl_bytecnt, big_endian_q,
    input  cbus_wready, cbus_rready,
    output ctl_ready, ctl_done,
    output cbus_req, cbus_dir, cbus_address, cbus_bytecnt, cbus_byten,
    output cbus_first, cbus_last
  );

  modport slave (
    output ctl_req, ctl_dir, ctl_address, ctl_bytecnt, big_endian_q,
    output cbus_wready, cbus_rready,
    input  ctl_ready, ctl_done,
    input  cbus_req, cbus_dir, cbus_address, cbus_bytecnt, cbus_byten,
    input  cbus_first, cbus_last
  );
endinterface

// File: rtl/generic_cbus_master_xfer_ctl_byten_gen.sv
// Per-beat lane math: byte enables, bytes consumed and last-beat flag.
module cbus_byten_gen
  import cbus_xfer_pkg::*;
#(
  parameter int unsigned BUS_BYTES = 4,
  parameter int unsigned BCNT_W    = 10,
  localparam int unsigned OFF_W    = cbus_off_w(BUS_BYTES),
  localparam int unsigned CW       = BCNT_W + 1
) (
  input  logic [OFF_W-1:0]     offset,
  input  logic [BCNT_W-1:0]    bytecnt,
  input  logic                 big_endian_q,
  output logic [BUS_BYTES-1:0] byten,
  output logic [CW-1:0]        consumed,
  output logic                 last
);

  logic [CW-1:0]        off_x;
  logic [CW-1:0]        cnt_x;
  logic [CW-1:0]        room;
  logic [CW-1:0]        lane_end;
  logic [BUS_BYTES-1:0] mask;

  // Widened arithmetic keeps room/lane_end free of wrap for any legal count.
  always_comb begin
    off_x    = CW'(offset);
    cnt_x    = CW'(bytecnt);
    room     = CW'(BUS_BYTES) - off_x;
    lane_end = off_x + cnt_x;
    consumed = (cnt_x < room) ? cnt_x : room;
    last     = (cnt_x <= room);
    mask     = '0;
    for (int i = 0; i < int'(BUS_BYTES); i++) begin
      mask[i] = (CW'(i) >= off_x) && (CW'(i) < lane_end);
    end
    byten = mask;
    if (big_endian_q) begin
      for (int i = 0; i < int'(BUS_BYTES); i++) begin
        byten[i] = mask[int'(BUS_BYTES) - 1 - i];
      end
    end
  end

endmodule

// File: rtl/generic_cbus_master_xfer_ctl.sv
// CBUS master transfer controller: splits one command into CBUS beats.
module generic_cbus_master_xfer_ctl
  import cbus_xfer_pkg::*;
#(
  parameter int unsigned BUS_BYTES = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BCNT_W    = 10
) (
  input logic                     cbus_clk,
  input logic                     rst,
  generic_cbus_master_xfer_ctl_if.master bus
);

  localparam int unsigned OFF_W = cbus_off_w(BUS_BYTES);
  localparam int unsigned CW    = BCNT_W + 1;

  localparam logic [1:0] ST_IDLE = 2'(XFER_IDLE);
  localparam logic [1:0] ST_XFER = 2'(XFER_XFER);
  localparam logic [1:0] ST_DONE = 2'(XFER_DONE);

  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(BUS_BYTES - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BUS_BYTES);

  logic [1:0]           st_q,    st_d;
  logic                 req_q,   req_d;
  logic                 dir_q,   dir_d;
  logic [ADDR_W-1:0]    addr_q,  addr_d;
  logic [BCNT_W-1:0]    cnt_q,   cnt_d;
  logic [BUS_BYTES-1:0] byten_q, byten_d;
  logic                 first_q, first_d;
  logic                 last_q,  last_d;
  logic                 done_q,  done_d;
  logic [CW-1:0]        cons_q,  cons_d;

  logic                 accept;
  logic [ADDR_W-1:0]    nxt_addr;
  logic [BCNT_W-1:0]    nxt_cnt;
  logic [ADDR_W-1:0]    gen_addr;
  logic [BCNT_W-1:0]    gen_cnt;
  logic [BUS_BYTES-1:0] gen_byten;
  logic [CW-1:0]        gen_consumed;
  logic                 gen_last;

  // Lane math always runs on the beat about to be registered.
  always_comb begin
    accept   = req_q && ((dir_q == CBUS_DIR_RD) ? bus.cbus_rready : bus.cbus_wready);
    nxt_addr = (addr_q & ~ADDR_MASK) + ADDR_STEP;
    nxt_cnt  = BCNT_W'(CW'(cnt_q) - cons_q);
    gen_addr = (st_q == ST_XFER) ? nxt_addr : bus.ctl_address;
    gen_cnt  = (st_q == ST_XFER) ? nxt_cnt  : bus.ctl_bytecnt;
  end

  cbus_byten_gen #(
    .BUS_BYTES (BUS_BYTES),
    .BCNT_W    (BCNT_W)
  ) u_byten_gen (
    .offset       (gen_addr[OFF_W-1:0]),
    .bytecnt      (gen_cnt),
    .big_endian_q (bus.big_endian_q),
    .byten        (gen_byten),
    .consumed     (gen_consumed),
    .last         (gen_last)
  );

  always_ff @(posedge cbus_clk) begin
    if (rst) begin
      st_q    <= ST_IDLE;
      req_q   <= 1'b0;
      dir_q   <= CBUS_DIR_WR;
      addr_q  <= '0;
      cnt_q   <= '0;
      byten_q <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      cons_q  <= '0;
    end else begin
      st_q    <= st_d;
      req_q   <= req_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      byten_q <= byten_d;
      first_q <= first_d;
      last_q  <= last_d;
      done_q  <= done_d;
      cons_q  <= cons_d;
    end
  end

  // Next state and next beat registers.
  always_comb begin
    st_d    = st_q;
    req_d   = req_q;
    dir_d   = dir_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    byten_d = byten_q;
    first_d = first_q;
    last_d  = last_q;
    done_d  = 1'b0;
    cons_d  = cons_q;
    case (st_q)
      ST_IDLE: begin
        if (bus.ctl_req) begin
          if (bus.ctl_bytecnt != '0) begin
            st_d    = ST_XFER;
            req_d   = 1'b1;
            dir_d   = bus.ctl_dir;
            addr_d  = bus.ctl_address;
            cnt_d   = bus.ctl_bytecnt;
            byten_d = gen_byten;
            cons_d  = gen_consumed;
            last_d  = gen_last;
            first_d = 1'b1;
          end else begin
            st_d   = ST_DONE;
            done_d = 1'b1;
          end
        end
      end
      ST_XFER: begin
        if (accept) begin
          if (last_q) begin
            st_d    = ST_DONE;
            req_d   = 1'b0;
            first_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            addr_d  = nxt_addr;
            cnt_d   = nxt_cnt;
            byten_d = gen_byten;
            cons_d  = gen_consumed;
            last_d  = gen_last;
            first_d = 1'b0;
          end
        end
      end
      ST_DONE: st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  assign bus.ctl_ready    = (st_q == ST_IDLE);
  assign bus.ctl_done     = done_q;
  assign bus.cbus_req     = req_q;
  assign bus.cbus_dir     = dir_q;
  assign bus.cbus_address = addr_q;
  assign bus.cbus_bytecnt = cnt_q;
  assign bus.cbus_byten   = byten_q;
  assign bus.cbus_first   = first_q;
  assign bus.cbus_last    = last_q;

endmodule

// File: tb/tb_generic_cbus_master_xfer_ctl.sv
// Directed bench for the CBUS transfer controller at 4- and 8-byte bus widths.
module tb_generic_cbus_master_xfer_ctl;

  logic cbus_clk;
  logic rst;
  int   n_vec;
  int   n_err;

  generic_cbus_master_xfer_ctl_if #(.BUS_BYTES(4), .ADDR_W(32), .BCNT_W(10)) b4 ();
  generic_cbus_master_xfer_ctl_if #(.BUS_BYTES(8), .ADDR_W(32), .BCNT_W(10)) b8 ();

  generic_cbus_master_xfer_ctl #(.BUS_BYTES(4), .ADDR_W(32), .BCNT_W(10)) dut4 (
    .cbus_clk (cbus_clk),
    .rst      (rst),
    .bus      (b4)
  );

  generic_cbus_master_xfer_ctl #(.BUS_BYTES(8), .ADDR_W(32), .BCNT_W(10)) dut8 (
    .cbus_clk (cbus_clk),
    .rst      (rst),
    .bus      (b8)
  );

  initial cbus_clk = 1'b0;
  always #5 cbus_clk = ~cbus_clk;

  logic [31:0] e8_addr  [4] = '{32'h1005, 32'h1008, 32'h1010, 32'h1018};
  logic [7:0]  e8_byten [4] = '{8'hE0, 8'hFF, 8'hFF, 8'h01};
  logic [9:0]  e8_cnt   [4] = '{10'd20, 10'd17, 10'd9, 10'd1};

  task automatic tick();
    @(posedge cbus_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat4(input string tag, input logic [31:0] a, input logic [3:0] be,
                       input logic [9:0] c, input logic f, input logic l);
    chk({tag, ".req"},   64'(b4.cbus_req), 64'(1'b1));
    chk({tag, ".addr"},  64'(b4.cbus_address), 64'(a));
    chk({tag, ".byten"}, 64'(b4.cbus_byten), 64'(be));
    chk({tag, ".cnt"},   64'(b4.cbus_bytecnt), 64'(c));
    chk({tag, ".first"}, 64'(b4.cbus_first), 64'(f));
    chk({tag, ".last"},  64'(b4.cbus_last), 64'(l));
  endtask

  task automatic beat8(input string tag, input logic [31:0] a, input logic [7:0] be,
                       input logic [9:0] c, input logic f, input logic l);
    chk({tag, ".req"},   64'(b8.cbus_req), 64'(1'b1));
    chk({tag, ".dir"},   64'(b8.cbus_dir), 64'(1'b1));
    chk({tag, ".addr"},  64'(b8.cbus_address), 64'(a));
    chk({tag, ".byten"}, 64'(b8.cbus_byten), 64'(be));
    chk({tag, ".cnt"},   64'(b8.cbus_bytecnt), 64'(c));
    chk({tag, ".first"}, 64'(b8.cbus_first), 64'(f));
    chk({tag, ".last"},  64'(b8.cbus_last), 64'(l));
  endtask

  task automatic idle4(input string tag, input logic done);
    chk({tag, ".req"},   64'(b4.cbus_req), 64'(1'b0));
    chk({tag, ".done"},  64'(b4.ctl_done), 64'(done));
    chk({tag, ".ready"}, 64'(b4.ctl_ready), 64'(!done));
  endtask

  task automatic cmd4(input logic d, input logic [31:0] a, input logic [9:0] c);
    b4.ctl_req     = 1'b1;
    b4.ctl_dir     = d;
    b4.ctl_address = a;
    b4.ctl_bytecnt = c;
    tick();
    b4.ctl_req     = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    b4.ctl_req = 0; b4.ctl_dir = 0; b4.ctl_address = 0; b4.ctl_bytecnt = 0;
    b4.big_endian_q = 0; b4.cbus_wready = 0; b4.cbus_rready = 0;
    b8.ctl_req = 0; b8.ctl_dir = 0; b8.ctl_address = 0; b8.ctl_bytecnt = 0;
    b8.big_endian_q = 0; b8.cbus_wready = 0; b8.cbus_rready = 0;
    tick();
    tick();
    chk("rst.req",   64'(b4.cbus_req), 64'(0));
    chk("rst.addr",  64'(b4.cbus_address), 64'(0));
    chk("rst.byten", 64'(b4.cbus_byten), 64'(0));
    chk("rst.done",  64'(b4.ctl_done), 64'(0));
    chk("rst.ready", 64'(b4.ctl_ready), 64'(1));
    chk("rst8.ready", 64'(b8.ctl_ready), 64'(1));
    rst = 1'b0;
    tick();

    // aligned 10-byte write, slave always ready
    b4.cbus_wready = 1'b1;
    cmd4(1'b0, 32'h100, 10'd10);
    chk("w10.ready", 64'(b4.ctl_ready), 64'(0));
    chk("w10.dir",   64'(b4.cbus_dir), 64'(0));
    beat4("w10.b0", 32'h100, 4'b1111, 10'd10, 1'b1, 1'b0);
    tick();
    beat4("w10.b1", 32'h104, 4'b1111, 10'd6, 1'b0, 1'b0);
    tick();
    beat4("w10.b2", 32'h108, 4'b0011, 10'd2, 1'b0, 1'b1);
    tick();
    idle4("w10.done", 1'b1);
    tick();
    idle4("w10.idle", 1'b0);

    // unaligned 5-byte write, little then big endian lanes
    cmd4(1'b0, 32'h102, 10'd5);
    beat4("u5le.b0", 32'h102, 4'b1100, 10'd5, 1'b1, 1'b0);
    tick();
    beat4("u5le.b1", 32'h104, 4'b0111, 10'd3, 1'b0, 1'b1);
    tick();
    idle4("u5le.done", 1'b1);
    tick();
    b4.big_endian_q = 1'b1;
    cmd4(1'b0, 32'h102, 10'd5);
    beat4("u5be.b0", 32'h102, 4'b0011, 10'd5, 1'b1, 1'b0);
    tick();
    beat4("u5be.b1", 32'h104, 4'b1110, 10'd3, 1'b0, 1'b1);
    tick();
    idle4("u5be.done", 1'b1);
    tick();
    b4.big_endian_q = 1'b0;

    // 8-byte bus read with rready toggling; wready must not advance beats
    b8.cbus_wready = 1'b1;
    b8.cbus_rready = 1'b0;
    b8.ctl_req     = 1'b1;
    b8.ctl_dir     = 1'b1;
    b8.ctl_address = 32'h1005;
    b8.ctl_bytecnt = 10'd20;
    tick();
    b8.ctl_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b8.cbus_rready = 1'b0;
      beat8($sformatf("r20.b%0d", k), e8_addr[k], e8_byten[k], e8_cnt[k], k == 0, k == 3);
      tick();
      chk($sformatf("r20.hold%0d", k), 64'(b8.cbus_address), 64'(e8_addr[k]));
      b8.cbus_rready = 1'b1;
      tick();
    end
    b8.cbus_rready = 1'b0;
    chk("r20.req",  64'(b8.cbus_req), 64'(0));
    chk("r20.done", 64'(b8.ctl_done), 64'(1));
    tick();
    chk("r20.ready", 64'(b8.ctl_ready), 64'(1));

    // zero-length command, then a command right at ready
    cmd4(1'b0, 32'h180, 10'd0);
    idle4("z.done", 1'b1);
    tick();
    idle4("z.idle", 1'b0);
    cmd4(1'b0, 32'h200, 10'd4);
    beat4("z.next", 32'h200, 4'b1111, 10'd4, 1'b1, 1'b1);
    tick();
    idle4("z.next.done", 1'b1);
    tick();

    // reset during the second beat
    cmd4(1'b0, 32'h100, 10'd10);
    tick();
    beat4("rs.b1", 32'h104, 4'b1111, 10'd6, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle4("rs.after", 1'b0);
    chk("rs.addr",  64'(b4.cbus_address), 64'(0));
    chk("rs.cnt",   64'(b4.cbus_bytecnt), 64'(0));
    chk("rs.byten", 64'(b4.cbus_byten), 64'(0));
    chk("rs.first", 64'(b4.cbus_first), 64'(0));
    chk("rs.last",  64'(b4.cbus_last), 64'(0));
    tick();
    chk("rs.nodone", 64'(b4.ctl_done), 64'(0));
    b4.cbus_wready = 1'b0;
    cmd4(1'b0, 32'h300, 10'd6);
    beat4("rs.new.b0", 32'h300, 4'b1111, 10'd6, 1'b1, 1'b0);
    tick();
    beat4("rs.new.stall", 32'h300, 4'b1111, 10'd6, 1'b1, 1'b0);
    b4.cbus_rready = 1'b1;
    tick();
    beat4("rs.new.rign", 32'h300, 4'b1111, 10'd6, 1'b1, 1'b0);
    b4.cbus_rready = 1'b0;
    b4.cbus_wready = 1'b1;
    tick();
    beat4("rs.new.b1", 32'h304, 4'b0011, 10'd2, 1'b0, 1'b1);
    tick();
    idle4("rs.new.done", 1'b1);
    tick();

    // ctl_req held high: one command per ready window
    b4.ctl_req     = 1'b1;
    b4.ctl_dir     = 1'b0;
    b4.ctl_address = 32'h400;
    b4.ctl_bytecnt = 10'd8;
    tick();
    beat4("hold.b0", 32'h400, 4'b1111, 10'd8, 1'b1, 1'b0);
    tick();
    beat4("hold.b1", 32'h404, 4'b1111, 10'd4, 1'b0, 1'b1);
    tick();
    idle4("hold.done", 1'b1);
    tick();
    idle4("hold.idle", 1'b0);
    tick();
    b4.ctl_req = 1'b0;
    beat4("hold.again", 32'h400, 4'b1111, 10'd8, 1'b1, 1'b0);
    tick();
    tick();
    idle4("hold.again.done", 1'b1);
    tick();
    idle4("hold.again.idle", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
